// File: rtl/wr_regfile.sv
// -----------------------------------------------------------------------------
// wr_regfile -- write-back stage plus general-purpose register file.
//
// Selects the write-back value from the Mem/Wr segment register, commits it
// to GPR[1..31] on the rising edge, maintains the HI/LO pair for
// MULT/MULTU/MTHI/MTLO, and counts retired GPR writes.
// The segment registers feeding this block change on the falling edge, so
// each write-back value is stable for the whole high phase before the commit.
//
// Ports
//   clk, rst_n        : clock; asynchronous active-low reset
//   Wr_op, Wr_func    : opcode / function field of the retiring instruction
//   Wr_Reg            : destination GPR number
//   Wr_RegWr          : GPR write enable
//   Wr_MemtoReg       : 1 selects load data for write-back
//   Wr_alure          : ALU result
//   Wr_dout           : load data
//   Wr_busA           : rs operand (source for MTHI/MTLO)
//   Wr_MULT_result    : 64-bit product from the multiplier
//   ra1, ra2          : decode-stage read addresses
//   rd1, rd2          : read data, with same-cycle bypass of the pending write
//   wb_data, wb_we    : effective write-back data / GPR write enable
//   hi, lo            : current HI / LO registers
//   wb_count          : retired GPR write counter, wraps silently
// -----------------------------------------------------------------------------
module wr_regfile #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       Wr_op,
  input  logic [5:0]       Wr_func,
  input  logic [4:0]       Wr_Reg,
  input  logic             Wr_RegWr,
  input  logic             Wr_MemtoReg,
  input  logic [31:0]      Wr_alure,
  input  logic [31:0]      Wr_dout,
  input  logic [31:0]      Wr_busA,
  input  logic [63:0]      Wr_MULT_result,
  input  logic [4:0]       ra1,
  input  logic [4:0]       ra2,
  output logic [31:0]      rd1,
  output logic [31:0]      rd2,
  output logic [31:0]      wb_data,
  output logic             wb_we,
  output logic [31:0]      hi,
  output logic [31:0]      lo,
  output logic [CNT_W-1:0] wb_count
);

  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MTHI  = 6'b010001;
  localparam logic [5:0] FN_MFLO  = 6'b010010;
  localparam logic [5:0] FN_MTLO  = 6'b010011;

  // Instruction decode (R-type only carries these functions)
  logic is_rtype;
  logic is_mult;
  logic is_mfhi;
  logic is_mthi;
  logic is_mflo;
  logic is_mtlo;

  assign is_rtype = (Wr_op == 6'b000000);
  assign is_mult  = is_rtype && ((Wr_func == FN_MULT) || (Wr_func == FN_MULTU));
  assign is_mfhi  = is_rtype && (Wr_func == FN_MFHI);
  assign is_mthi  = is_rtype && (Wr_func == FN_MTHI);
  assign is_mflo  = is_rtype && (Wr_func == FN_MFLO);
  assign is_mtlo  = is_rtype && (Wr_func == FN_MTLO);

  // Architectural state
  logic [31:0]      gpr [32];
  logic [31:0]      hi_q;
  logic [31:0]      lo_q;
  logic [CNT_W-1:0] cnt_q;

  // Write-back select: load data beats MFHI/MFLO, which beat the ALU result.
  // MFHI/MFLO see the registered HI/LO, i.e. the value before this edge.
  always_comb begin
    wb_data = Wr_alure;
    if (Wr_MemtoReg)  wb_data = Wr_dout;
    else if (is_mfhi) wb_data = hi_q;
    else if (is_mflo) wb_data = lo_q;
  end

  // Register 0 is hardwired, so a write to it is not a retired write.
  assign wb_we = Wr_RegWr && (Wr_Reg != 5'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) gpr[i] <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (wb_we) begin
        gpr[Wr_Reg] <= wb_data;
        cnt_q       <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      // HI/LO updates do not depend on Wr_RegWr
      if (is_mult) begin
        hi_q <= Wr_MULT_result[63:32];
        lo_q <= Wr_MULT_result[31:0];
      end else if (is_mthi) begin
        hi_q <= Wr_busA;
      end else if (is_mtlo) begin
        lo_q <= Wr_busA;
      end
    end
  end

  // Read ports: address 0 reads zero; a matching pending write is bypassed
  // so decode sees the value in the same cycle it is being written back.
  assign rd1 = (ra1 == 5'd0)                ? 32'd0   :
               (wb_we && (ra1 == Wr_Reg))   ? wb_data : gpr[ra1];
  assign rd2 = (ra2 == 5'd0)                ? 32'd0   :
               (wb_we && (ra2 == Wr_Reg))   ? wb_data : gpr[ra2];

  assign hi       = hi_q;
  assign lo       = lo_q;
  assign wb_count = cnt_q;

endmodule
